// File: rtl/alu_pkg.sv
// alu_pkg
//   Op-code constants shared by the pipelined ALU, its adder and anything that
//   drives it. Codes occupy the full 3-bit select space, so every value is a
//   defined operation.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;  // x + y + cin
  localparam logic [2:0] OP_SUB = 3'b001;  // x + ~y + 1
  localparam logic [2:0] OP_NOT = 3'b010;  // ~x
  localparam logic [2:0] OP_AND = 3'b011;  // x & y
  localparam logic [2:0] OP_OR  = 3'b100;  // x | y
  localparam logic [2:0] OP_XOR = 3'b101;  // x ^ y
  localparam logic [2:0] OP_SLT = 3'b110;  // signed x < y
  localparam logic [2:0] OP_EQ  = 3'b111;  // x == y

endpackage

// File: rtl/alu_adder.sv
// alu_adder
//   WIDTH-bit ripple adder shared by ADD and SUB (SUB feeds ~y with cin=1).
// Ports
//   cin       carry in
//   a, b      WIDTH-bit operands
//   sum       WIDTH-bit truncated sum
//   carry     carry out of the MSB (for SUB: 1 = no borrow)
//   overflow  two's-complement overflow of a + b + cin
module alu_adder #(
  parameter int WIDTH = 4
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum      = full_sum[WIDTH-1:0];
  assign carry    = full_sum[WIDTH];
  // Signed overflow: operands agree in sign but the result does not.
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
//   Two-stage pipelined ALU with valid/ready on both sides. Stage 1 holds the
//   accepted operands, stage 2 holds the registered result and flags. Latency
//   is two cycles, throughput one op per cycle. A sticky overflow flag and a
//   saturating count of consumed results feed the board debug display.
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   input handshake (select, in_c, in_x, in_y)
//   out_valid / out_ready output handshake (out_s, out_c, zero, overflow)
//   ovf_sticky            set by any loaded result with overflow=1
//   clr_sticky            clears ovf_sticky (a same-cycle set wins)
//   op_count              consumed results, saturating at all-ones
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           select,
  input  logic                 in_c,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_s,
  output logic                 out_c,
  output logic                 zero,
  output logic                 overflow,
  output logic                 ovf_sticky,
  input  logic                 clr_sticky,
  output logic [CNT_WIDTH-1:0] op_count
);

  // Stage 1 operand register
  logic             s1_valid_reg;
  logic [2:0]       s1_sel_reg;
  logic             s1_c_reg;
  logic [WIDTH-1:0] s1_x_reg;
  logic [WIDTH-1:0] s1_y_reg;

  logic s2_adv;
  logic s1_adv;

  // Stage 2 may load whenever it is empty or its result leaves this cycle;
  // stage 1 can take new operands whenever its contents move on (or it is empty).
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid_reg && s2_adv;
  assign in_ready = !s1_valid_reg || s2_adv;

  // Shared adder: SUB is x + ~y + 1, and in_c only matters for ADD.
  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             add_ovf;

  assign is_sub  = (s1_sel_reg == OP_SUB);
  assign add_b   = is_sub ? ~s1_y_reg : s1_y_reg;
  assign add_cin = is_sub ? 1'b1 : s1_c_reg;

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .cin      (add_cin),
    .a        (s1_x_reg),
    .b        (add_b),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_ovf)
  );

  // Result decode from stage 1
  logic [WIDTH-1:0] res_s;
  logic             res_c;
  logic             res_v;

  always_comb begin
    res_s = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (s1_sel_reg)
      OP_ADD, OP_SUB: begin
        res_s = add_sum;
        res_c = add_carry;
        res_v = add_ovf;
      end
      OP_NOT: res_s = ~s1_x_reg;
      OP_AND: res_s = s1_x_reg & s1_y_reg;
      OP_OR:  res_s = s1_x_reg | s1_y_reg;
      OP_XOR: res_s = s1_x_reg ^ s1_y_reg;
      OP_SLT: res_s[0] = ($signed(s1_x_reg) < $signed(s1_y_reg));
      OP_EQ:  res_s[0] = (s1_x_reg == s1_y_reg);
      default: res_s = '0;
    endcase
  end

  // Stage 1: reload whenever there is room; in_valid low simply empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sel_reg   <= '0;
      s1_c_reg     <= 1'b0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_sel_reg <= select;
        s1_c_reg   <= in_c;
        s1_x_reg   <= in_x;
        s1_y_reg   <= in_y;
      end
    end
  end

  // Stage 2: data only changes on a real load, so outputs hold while stalled
  // and keep their last value after the consumer drains the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_c     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_s    <= res_s;
        out_c    <= res_c;
        zero     <= (res_s == '0);
        overflow <= res_v;
      end
    end
  end

  // Sticky overflow: a loading overflow takes priority over a clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (s1_adv && res_v) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

  // Consumed-result counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != {CNT_WIDTH{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
//   Instance A (WIDTH=4, CNT_WIDTH=8): directed cases plus randomized traffic
//   checked every cycle against an arithmetic reference model and a FIFO of
//   in-flight results. Instance B (WIDTH=8, CNT_WIDTH=2): directed wide-operand
//   ops and counter saturation.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    int s;
    int c;
    int z;
    int v;
  } res_t;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A
  logic       in_valid, in_ready, in_c, out_valid, out_ready;
  logic [2:0] select;
  logic [3:0] in_x, in_y, out_s;
  logic       out_c, zero, overflow, ovf_sticky, clr_sticky;
  logic [7:0] op_count;

  alu_pipe #(.WIDTH(4), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .in_c(in_c), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_c(out_c), .zero(zero), .overflow(overflow),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  // Instance B
  logic       b_in_valid, b_in_ready, b_in_c, b_out_valid, b_out_ready;
  logic [2:0] b_select;
  logic [7:0] b_in_x, b_in_y, b_out_s;
  logic       b_out_c, b_zero, b_overflow, b_ovf_sticky, b_clr_sticky;
  logic [1:0] b_op_count;

  alu_pipe #(.WIDTH(8), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .select(b_select), .in_c(b_in_c), .in_x(b_in_x), .in_y(b_in_y),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_s(b_out_s),
    .out_c(b_out_c), .zero(b_zero), .overflow(b_overflow),
    .ovf_sticky(b_ovf_sticky), .clr_sticky(b_clr_sticky), .op_count(b_op_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned/signed operand values.
  function automatic res_t model(input int w, input int sel, input int c,
                                 input int x, input int y);
    res_t r;
    int m, h, sx, sy, full, sv;
    m  = 1 << w;
    h  = 1 << (w - 1);
    sx = (x >= h) ? x - m : x;
    sy = (y >= h) ? y - m : y;
    r.c = 0;
    r.v = 0;
    case (sel)
      0: begin
        full = x + y + c;
        r.s = full % m;
        r.c = (full >= m) ? 1 : 0;
        sv = sx + sy + c;
        r.v = (sv >= h || sv < -h) ? 1 : 0;
      end
      1: begin
        r.s = (x - y + m) % m;
        r.c = (x >= y) ? 1 : 0;
        sv = sx - sy;
        r.v = (sv >= h || sv < -h) ? 1 : 0;
      end
      2: r.s = m - 1 - x;
      3: r.s = x & y;
      4: r.s = x | y;
      5: r.s = x ^ y;
      6: r.s = (sx < sy) ? 1 : 0;
      default: r.s = (x == y) ? 1 : 0;
    endcase
    r.z = (r.s == 0) ? 1 : 0;
    return r;
  endfunction

  // Edge monitor for instance A: records handshakes seen at each rising edge.
  res_t mq[$];
  int   consumed[$];
  bit   armed = 0;
  bit   p_rst, p_ov, p_or, p_clr;

  initial forever begin
    @(posedge clk);
    p_rst = rst;
    p_ov  = out_valid;
    p_or  = out_ready;
    p_clr = clr_sticky;
    if (rst) begin
      armed = 1;
      mq.delete();
      consumed.delete();
    end else begin
      if (in_valid && in_ready)
        mq.push_back(model(4, int'(select), int'(in_c), int'(in_x), int'(in_y)));
      if (out_valid && out_ready)
        consumed.push_back(int'(out_s));
    end
  end

  // Compare process for instance A, sampled mid-cycle.
  int exp_sticky = 0;
  int exp_cnt = 0;
  int held_s, held_c, held_z, held_v;

  initial forever begin
    res_t e, dropped;
    bit new_load;
    @(negedge clk);
    if (armed) begin
      if (p_rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_s", out_s, 0);
        chk("rst_flags", {out_c, zero, overflow}, 0);
        chk("rst_in_ready", in_ready, 1);
        exp_sticky = 0;
        exp_cnt = 0;
      end else begin
        if (p_ov && p_or) begin
          if (mq.size() > 0) dropped = mq.pop_front();
          if (exp_cnt < 255) exp_cnt++;
        end
        new_load = out_valid && (!p_ov || p_or);
        if (new_load) begin
          if (mq.size() == 0) begin
            fails++;
            tests++;
            $display("FAIL unexpected_result: got out_s=%0d, expected no result", out_s);
          end else begin
            e = mq[0];
            chk("res_s", out_s, e.s);
            chk("res_c", out_c, e.c);
            chk("res_zero", zero, e.z);
            chk("res_ovf", overflow, e.v);
            held_s = e.s; held_c = e.c; held_z = e.z; held_v = e.v;
            if (e.v != 0) exp_sticky = 1;
            else if (p_clr) exp_sticky = 0;
          end
        end else begin
          if (p_clr) exp_sticky = 0;
          if (out_valid) begin
            chk("hold_s", out_s, held_s);
            chk("hold_flags", {out_c, zero, overflow}, {held_c[0], held_z[0], held_v[0]});
          end
        end
        chk("ovf_sticky", ovf_sticky, exp_sticky);
        chk("op_count", op_count, exp_cnt);
      end
    end
  end

  // Single op through an idle A pipe; outputs are checked by the caller right
  // after the edge that loads stage 2.
  task automatic run_a(input logic [2:0] sel, input logic c, input logic [3:0] x,
                       input logic [3:0] y, input logic clr_on_load);
    @(negedge clk); #2;
    in_valid = 1; select = sel; in_c = c; in_x = x; in_y = y; out_ready = 1;
    #1 chk("run_a_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    clr_sticky = clr_on_load;
    @(posedge clk); #1;
    clr_sticky = 0;
  endtask

  task automatic run_b(input logic [2:0] sel, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk); #2;
    b_in_valid = 1; b_select = sel; b_in_c = 0; b_in_x = x; b_in_y = y;
    @(posedge clk); #1;
    b_in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear;
    @(negedge clk); #2 clr_sticky = 1;
    @(posedge clk); #1 clr_sticky = 0;
  endtask

  initial begin
    int k;
    bit acc;
    in_valid = 0; select = 0; in_c = 0; in_x = 0; in_y = 0; out_ready = 0; clr_sticky = 0;
    b_in_valid = 0; b_select = 0; b_in_c = 0; b_in_x = 0; b_in_y = 0;
    b_out_ready = 1; b_clr_sticky = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_sticky", ovf_sticky, 0);

    // WIDTH=8 ops and CNT_WIDTH=2 saturation
    run_b(OP_SLT, 8'hFF, 8'h01); chk("b_slt", b_out_s, 1);
    run_b(OP_EQ, 8'hA5, 8'hA5);  chk("b_eq", b_out_s, 1);
    run_b(OP_NOT, 8'h0F, 8'h00); chk("b_not", b_out_s, 8'hF0);
    run_b(OP_ADD, 8'h7F, 8'h01); chk("b_add_s", b_out_s, 8'h80); chk("b_add_ovf", b_overflow, 1);
    run_b(OP_SUB, 8'h00, 8'h01); chk("b_sub_s", b_out_s, 8'hFF); chk("b_sub_c", b_out_c, 0);
    repeat (2) @(posedge clk);
    #1 chk("b_count_sat", b_op_count, 3);

    // Hand-computed WIDTH=4 results
    run_a(OP_ADD, 0, 4'd7, 4'd1, 0);
    chk("t1_s", out_s, 8); chk("t1_c", out_c, 0); chk("t1_ovf", overflow, 1);
    chk("t1_zero", zero, 0); chk("t1_sticky", ovf_sticky, 1);
    run_a(OP_SUB, 0, 4'd3, 4'd3, 0);
    chk("t2a_s", out_s, 0); chk("t2a_zero", zero, 1); chk("t2a_c", out_c, 1); chk("t2a_ovf", overflow, 0);
    run_a(OP_SUB, 0, 4'd0, 4'd1, 0);
    chk("t2b_s", out_s, 15); chk("t2b_c", out_c, 0);

    // Clear versus set in the same cycle
    pulse_clear();
    chk("t5_cleared", ovf_sticky, 0);
    run_a(OP_ADD, 0, 4'd7, 4'd1, 1);
    chk("t5_set_wins", ovf_sticky, 1);
    pulse_clear();
    chk("t5_clear_alone", ovf_sticky, 0);

    // Back-to-back with a stalled consumer
    @(negedge clk); #2 rst = 1;
    @(posedge clk); #1 rst = 0;
    k = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk); #2;
      out_ready = (cyc >= 3);
      in_valid = (k < 4);
      select = OP_ADD; in_c = 0; in_x = 4'(k + 1); in_y = 0;
      #1;
      if (cyc == 2) begin
        chk("t4_accepts_before_stall", k, 2);
        chk("t4_in_ready_low", in_ready, 0);
      end
      if (cyc == 2 || cyc == 3) chk("t4_held_s", out_s, 1);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) k++;
    end
    in_valid = 0;
    chk("t4_all_accepted", k, 4);
    chk("t4_consumed_n", consumed.size(), 4);
    for (int i = 0; i < 4 && i < consumed.size(); i++)
      chk("t4_order", consumed[i], i + 1);
    #1 chk("t4_op_count", op_count, 4);

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk); #2;
      in_valid   = ($urandom_range(0, 3) != 0);
      select     = 3'($urandom_range(0, 7));
      in_c       = 1'($urandom_range(0, 1));
      in_x       = 4'($urandom_range(0, 15));
      in_y       = 4'($urandom_range(0, 15));
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
    end

    // Drain, fill both stages, then reset
    @(negedge clk); #2;
    in_valid = 0; out_ready = 1; clr_sticky = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    out_ready = 0; in_valid = 1; select = OP_ADD; in_c = 0; in_x = 4'd7; in_y = 4'd1;
    @(posedge clk); #1;
    in_x = 4'd2; in_y = 4'd3;
    @(posedge clk); #1;
    in_valid = 0;
    chk("t6_full", in_ready, 0);
    chk("t6_sticky_before", ovf_sticky, 1);
    @(negedge clk); #2 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_flags", {out_c, zero, overflow}, 0);
    chk("t6_sticky", ovf_sticky, 0);
    chk("t6_op_count", op_count, 0);
    chk("t6_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 chk("t6_stays_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
